// File: rtl/psum_accumulator.sv
// Output-channel partial-sum accumulator. It adds routed per-slot psums into OUT_CH accumulators
// for NUM_PASS beats, then drains one channel per handshake. Optional clamping: PSUM_ACC_SAT_EN.
module psum_accumulator #(
  parameter int NUM_MACRO      = 1,
  parameter int MAX_NUM_FILTER = 1,
  parameter int OUT_CH         = 64,
  parameter int PSUM_W         = 19,
  parameter int ACC_W          = 24,
  parameter int NUM_PASS       = 9
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clear,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [NUM_MACRO*MAX_NUM_FILTER*OUT_CH-1:0] demux,
  input  logic [NUM_MACRO*MAX_NUM_FILTER*PSUM_W-1:0] psum_in,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [$clog2(OUT_CH)-1:0]                  out_ch,
  output logic signed [ACC_W-1:0]                    out_data,
  output logic                                       sat_flag
);

  localparam int NUM_SLOT = NUM_MACRO * MAX_NUM_FILTER;
  localparam int CH_W     = $clog2(OUT_CH);
  // The extra bits hold the accumulator plus every slot at full scale without overflow.
  localparam int SUM_W    = ACC_W + $clog2(NUM_SLOT + 1);
  localparam int PASS_W   = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(OUT_CH - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                   state_q;
  state_e                   state_d;
  logic [PASS_W-1:0]        pass_cnt_q;
  logic [CH_W-1:0]          drain_idx_q;
  logic [ACC_W-1:0]         acc_q    [OUT_CH];
  logic [ACC_W-1:0]         acc_next [OUT_CH];
  logic signed [SUM_W-1:0]  psum_ext [NUM_SLOT];
  logic signed [SUM_W-1:0]  total    [OUT_CH];
  logic                     beat;
  logic                     drain_acc;
  logic                     sat_hit;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign beat      = in_valid & in_ready;
  assign drain_acc = out_valid & out_ready;
  assign out_ch    = drain_idx_q;
  assign out_data  = out_valid ? acc_q[drain_idx_q] : '0;

  always_comb begin
    for (int s = 0; s < NUM_SLOT; s++) begin
      psum_ext[s] = {{(SUM_W-PSUM_W){psum_in[s*PSUM_W + PSUM_W - 1]}},
                     psum_in[s*PSUM_W +: PSUM_W]};
    end
  end

  // Each channel sums its own accumulator with every slot routed to it, all in one cycle.
  always_comb begin
    for (int c = 0; c < OUT_CH; c++) begin
      total[c] = {{(SUM_W-ACC_W){acc_q[c][ACC_W-1]}}, acc_q[c]};
      for (int s = 0; s < NUM_SLOT; s++) begin
        if (demux[s*OUT_CH + c]) begin
          total[c] = total[c] + psum_ext[s];
        end
      end
    end
  end

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic sat_q;

  always_comb begin
    sat_hit = 1'b0;
    for (int c = 0; c < OUT_CH; c++) begin
      if (total[c] > ACC_MAX) begin
        acc_next[c] = ACC_MAX[ACC_W-1:0];
        sat_hit     = 1'b1;
      end else if (total[c] < ACC_MIN) begin
        acc_next[c] = ACC_MIN[ACC_W-1:0];
        sat_hit     = 1'b1;
      end else begin
        acc_next[c] = total[c][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (clear) begin
      sat_q <= 1'b0;
    end else if (beat && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  // Dropping the upper bits gives modulo-2^ACC_W wrap-around.
  always_comb begin
    sat_hit = 1'b0;
    for (int c = 0; c < OUT_CH; c++) begin
      acc_next[c] = total[c][ACC_W-1:0];
    end
  end

  assign sat_flag = 1'b0;
`endif

  // clear overrides both the beat and the drain handshake.
  always_comb begin
    // NOTE: state_d gets a default before any branch, so every path assigns it and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (beat && (pass_cnt_q == LAST_PASS)) state_d = DRAIN;
      DRAIN: if (drain_acc && (drain_idx_q == LAST_CH)) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is built from reset flops, not RAM, because reset must zero every entry.
      state_q     <= ACCUM;
      pass_cnt_q  <= '0;
      drain_idx_q <= '0;
      for (int c = 0; c < OUT_CH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      // NOTE: all sequential state uses non-blocking assignments, so every register reads the values from before the edge.
      state_q <= state_d;
      if (clear) begin
        pass_cnt_q  <= '0;
        drain_idx_q <= '0;
        for (int c = 0; c < OUT_CH; c++) begin
          acc_q[c] <= '0;
        end
      end else if (beat) begin
        for (int c = 0; c < OUT_CH; c++) begin
          acc_q[c] <= acc_next[c];
        end
        pass_cnt_q <= (pass_cnt_q == LAST_PASS) ? '0 : pass_cnt_q + 1'b1;
      end else if (drain_acc) begin
        acc_q[drain_idx_q] <= '0;
        drain_idx_q        <= (drain_idx_q == LAST_CH) ? '0 : drain_idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator. It runs table-driven tiles, hand-written corner
// sequences, and randomized tiles compared against an arithmetic reference model.
module tb_psum_accumulator;

  localparam int NM = 2;
  localparam int NF = 2;
  localparam int OC = 4;
  localparam int PW = 8;
  localparam int AW = 10;
  localparam int NP = 3;
  localparam int NS = NM * NF;

`ifdef PSUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NS*OC-1:0]     demux = '0;
  logic [NS*PW-1:0]     psum_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [1:0]           out_ch;
  logic signed [AW-1:0] out_data;
  logic                 sat_flag;

  int errors = 0;
  int checks = 0;
  int model_acc [OC];
  bit model_sat;

  typedef struct packed {
    logic [NS*OC-1:0]       demux;
    logic [NS*PW-1:0]       psum;
    logic [OC-1:0][AW-1:0]  exp;
    logic                   exp_sat;
  } vec_t;

  vec_t vecs [5];

  psum_accumulator #(
    .NUM_MACRO(NM), .MAX_NUM_FILTER(NF), .OUT_CH(OC),
    .PSUM_W(PW), .ACC_W(AW), .NUM_PASS(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .demux(demux), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [31:0] p,
                              input int e0, input int e1, input int e2, input int e3,
                              input logic s);
    vec_t v;
    v.demux   = d;
    v.psum    = p;
    v.exp[0]  = AW'(e0);
    v.exp[1]  = AW'(e1);
    v.exp[2]  = AW'(e2);
    v.exp[3]  = AW'(e3);
    v.exp_sat = s;
    return v;
  endfunction

  function automatic int wrap_acc(input int v);
    int r;
    r = v & ((1 << AW) - 1);
    if (r >= (1 << (AW - 1))) r = r - (1 << AW);
    return r;
  endfunction

  // Reference: each channel gains the sum of the psums whose routing vector flags it.
  function automatic void model_beat(input logic [15:0] d, input logic [31:0] p);
    int sum;
    int v;
    logic signed [PW-1:0] b;
    for (int c = 0; c < OC; c++) begin
      sum = 0;
      for (int s = 0; s < NS; s++) begin
        if (d[s*OC + c]) begin
          b   = p[s*PW +: PW];
          sum = sum + int'(b);
        end
      end
      v = model_acc[c] + sum;
      if (SAT) begin
        if (v > 511) begin v = 511; model_sat = 1'b1; end
        else if (v < -512) begin v = -512; model_sat = 1'b1; end
      end else begin
        v = wrap_acc(v);
      end
      model_acc[c] = v;
    end
  endfunction

  task automatic beat(input logic [15:0] d, input logic [31:0] p);
    demux    = d;
    psum_in  = p;
    in_valid = 1'b1;
    check("in_ready_accum", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_expect(input logic [OC-1:0][AW-1:0] e);
    out_ready = 1'b1;
    for (int c = 0; c < OC; c++) begin
      check("drain_valid", int'(out_valid), 1);
      check("drain_ch", int'(out_ch), c);
      check("drain_data", int'(out_data), int'($signed(e[c])));
      step();
    end
    out_ready = 1'b0;
    check("ready_after_drain", int'(in_ready), 1);
    check("valid_after_drain", int'(out_valid), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [31:0] rp;
    int idx;

    vecs[0] = mk(16'h8421, 32'h04030201, 3, 6, 9, 12, 1'b0);
    vecs[1] = mk(16'h4444, 32'h0107FD05, 0, 0, 30, 0, 1'b0);
    vecs[2] = mk(16'h2202, 32'h1E14640A, 0, 180, 0, 0, 1'b0);
    vecs[3] = mk(16'h000F, 32'h000000F9, -21, -21, -21, -21, 1'b0);
    vecs[4] = mk(16'h1111, 32'h7F7F7F7F, SAT ? 511 : 500, 0, 0, 0, SAT);

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    rst_n = 1'b1;
    step();

    // Table-driven tiles: routing, collision, zero-demux slot, multi-bit slot, overflow.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < NP; b++) begin
        check("no_drain_early", int'(out_valid), 0);
        beat(vecs[i].demux, vecs[i].psum);
      end
      drain_expect(vecs[i].exp);
      check("tile_sat_flag", int'(sat_flag), int'(vecs[i].exp_sat));
      pulse_clear();
      check("sat_after_clear", int'(sat_flag), 0);
    end

    // Backpressure mid-drain at ch1, with beats offered during DRAIN.
    for (int b = 0; b < NP; b++) beat(16'h8421, 32'h04030201);
    out_ready = 1'b1;
    check("bp_ch0", int'(out_data), 3);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    demux     = 16'h1111;
    psum_in   = 32'h01010101;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_ch_hold", int'(out_ch), 1);
      check("bp_data_hold", int'(out_data), 6);
      check("bp_in_ready", int'(in_ready), 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 1; c < OC; c++) begin
      check("bp_rest_ch", int'(out_ch), c);
      check("bp_rest_data", int'(out_data), 3 * (c + 1));
      step();
    end
    out_ready = 1'b0;
    check("bp_in_ready_back", int'(in_ready), 1);
    for (int b = 0; b < NP; b++) beat(16'h0000, 32'h00000000);
    drain_expect({10'd0, 10'd0, 10'd0, 10'd0});

    // clear after two beats restarts the pass count and empties the accumulators.
    beat(16'h8421, 32'h04030201);
    beat(16'h8421, 32'h04030201);
    pulse_clear();
    check("clr_in_ready", int'(in_ready), 1);
    check("clr_out_valid", int'(out_valid), 0);
    beat(16'h0001, 32'h00000001);
    beat(16'h0001, 32'h00000001);
    check("clr_no_drain_yet", int'(out_valid), 0);
    beat(16'h0001, 32'h00000001);
    drain_expect({10'd0, 10'd0, 10'd0, 10'd3});

    // Asynchronous reset mid-drain.
    for (int b = 0; b < NP; b++) beat(16'h8421, 32'h04030201);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_ch", int'(out_ch), 0);
    check("arst_out_data", int'(out_data), 0);
    step();
    rst_n = 1'b1;
    step();
    for (int b = 0; b < NP; b++) beat(16'h0002, 32'h00000001);
    drain_expect({10'd0, 10'd0, 10'd3, 10'd0});

    // Randomized tiles with idle gaps and random backpressure.
    pulse_clear();
    model_sat = 1'b0;
    for (int c = 0; c < OC; c++) model_acc[c] = 0;
    for (int t = 0; t < 15; t++) begin
      for (int b = 0; b < NP; b++) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          check("rand_idle_valid", int'(out_valid), 0);
          step();
        end
        rd = 16'($urandom);
        rp = $urandom;
        model_beat(rd, rp);
        beat(rd, rp);
      end
      idx = 0;
      for (int cyc = 0; cyc < 200 && idx < OC; cyc++) begin
        out_ready = 1'($urandom_range(0, 1));
        check("rand_valid", int'(out_valid), 1);
        check("rand_ch", int'(out_ch), idx);
        check("rand_data", int'(out_data), model_acc[idx]);
        step();
        if (out_ready) begin
          model_acc[idx] = 0;
          idx++;
        end
      end
      out_ready = 1'b0;
      check("rand_drain_done", idx, OC);
      check("rand_in_ready", int'(in_ready), 1);
      check("rand_sat_flag", int'(sat_flag), int'(model_sat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
